// File: rtl/booth2_pp_generator_if.sv
// Operand-in / partial-product-out bundle for the Booth-2 PP generator.
// slave is the generator's view, master is the surrounding datapath's view.
interface booth2_pp_generator_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      mcand;
  logic [15:0]      mplier;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [16:0]      pp1;
  logic [16:0]      pp2;
  logic [16:0]      pp3;
  logic [16:0]      pp4;
  logic [16:0]      pp5;
  logic [16:0]      pp6;
  logic [16:0]      pp7;
  logic [16:0]      pp8;
  logic             ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, mcand, mplier, in_tag, out_ready,
    output in_ready, out_valid, ovf, out_tag,
    output pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8
  );

  modport master (
    output in_valid, mcand, mplier, in_tag, out_ready,
    input  in_ready, out_valid, ovf, out_tag,
    input  pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8
  );
endinterface

// File: rtl/booth2_pp_generator.sv
// Radix-4 Booth partial-product generator for a 16x16 signed multiplier.
// Two registered stages: operands, then eight 17-bit two's complement PPs.
module booth2_pp_generator #(
  parameter int TAG_W = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic flush,
  booth2_pp_generator_if.slave bus
);

  logic             s1_valid;
  logic [15:0]      s1_a;
  logic [15:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             out_valid;
  logic [16:0]      pp_q [8];
  logic             ovf_q;
  logic [TAG_W-1:0] tag_q;

  logic             adv2;
  logic             in_ready;
  logic             accept;

  logic [16:0]      pp_d [8];
  logic             ovf_d;
  logic [16:0]      b_ext;
  logic [17:0]      a18;
  logic [17:0]      mag;
  logic [17:0]      p18;
  logic [2:0]       bits;
  logic             sel_zero;
  logic             sel_one;
  logic             sel_two;

  assign adv2     = !out_valid | bus.out_ready;
  assign in_ready = !flush & (!s1_valid | adv2);
  assign accept   = bus.in_valid & in_ready;

  // b_ext[0] stands in for B[-1]
  assign b_ext = {s1_b, 1'b0};
  assign a18   = {{2{s1_a[15]}}, s1_a};

  always_comb begin
    ovf_d    = 1'b0;
    bits     = 3'b000;
    sel_zero = 1'b1;
    sel_one  = 1'b0;
    sel_two  = 1'b0;
    mag      = '0;
    p18      = '0;
    for (int i = 0; i < 8; i++) begin
      bits     = b_ext[2*i +: 3];
      sel_one  = bits[1] ^ bits[0];
      sel_two  = (bits == 3'b011) | (bits == 3'b100);
      sel_zero = !sel_one & !sel_two;
      unique case (1'b1)
        sel_zero: mag = '0;
        sel_one:  mag = a18;
        sel_two:  mag = {a18[16:0], 1'b0};
        default:  mag = '0;
      endcase
      p18     = bits[2] ? -mag : mag;
      pp_d[i] = p18[16:0];
      // 17-bit truncation is lossy only when the top two bits disagree
      ovf_d   = ovf_d | (p18[17] ^ p18[16]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      ovf_q     <= 1'b0;
      tag_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        pp_q[i] <= '0;
      end
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & !adv2);
      if (accept) begin
        s1_a   <= bus.mcand;
        s1_b   <= bus.mplier;
        s1_tag <= bus.in_tag;
      end
      if (adv2) begin
        out_valid <= s1_valid;
        ovf_q     <= ovf_d;
        tag_q     <= s1_tag;
        for (int i = 0; i < 8; i++) begin
          pp_q[i] <= pp_d[i];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ovf       = ovf_q;
  assign bus.out_tag   = tag_q;
  assign bus.pp1       = pp_q[0];
  assign bus.pp2       = pp_q[1];
  assign bus.pp3       = pp_q[2];
  assign bus.pp4       = pp_q[3];
  assign bus.pp5       = pp_q[4];
  assign bus.pp6       = pp_q[5];
  assign bus.pp7       = pp_q[6];
  assign bus.pp8       = pp_q[7];

endmodule

// File: tb/tb_booth2_pp_generator.sv
// Random and directed bench for the Booth-2 PP generator.
// Expected PPs come from integer digit arithmetic, not a bit-level encoder.
module tb_booth2_pp_generator;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [7:0][16:0] pp;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [15:0]      a;
    logic [15:0]      b;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  booth2_pp_generator_if #(.TAG_W(TAG_W)) bus ();

  booth2_pp_generator #(.TAG_W(TAG_W)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .flush     (flush),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   last_acc = 1'b0;
  exp_t stim[$];
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    int   d;
    int   p;
    logic [31:0] pv;
    e = '0;
    e.a = a;
    e.b = b;
    e.tag = tag;
    for (int i = 0; i < 8; i++) begin
      d = -2 * int'(b[2*i+1]) + int'(b[2*i]);
      if (i > 0) d = d + int'(b[2*i-1]);
      p = d * int'($signed(a));
      pv = p;
      e.pp[i] = pv[16:0];
      if (p > 65535 || p < -65536) e.ovf = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [7:0][16:0] observed();
    return {bus.pp8, bus.pp7, bus.pp6, bus.pp5,
            bus.pp4, bus.pp3, bus.pp2, bus.pp1};
  endfunction

  task automatic add(input logic [15:0] a, input logic [15:0] b);
    stim.push_back(model(a, b, TAG_W'($urandom)));
  endtask

  task automatic compare(input int mode);
    exp_t e;
    logic [7:0][16:0] obs;
    logic signed [31:0] s;
    logic signed [31:0] sum;
    logic signed [31:0] prod;
    e = q.pop_front();
    obs = observed();
    for (int i = 0; i < 8; i++)
      chk($sformatf("pp%0d a=%h b=%h", i + 1, e.a, e.b), obs[i], e.pp[i]);
    chk("ovf", bus.ovf, e.ovf);
    chk("out_tag", bus.out_tag, e.tag);
    if (!e.ovf) begin
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        s = {{15{obs[i][16]}}, obs[i]};
        sum = sum + (s <<< (2 * i));
      end
      prod = $signed(e.a);
      prod = prod * $signed({{16{e.b[15]}}, e.b});
      chk("pp_sum", sum, prod);
    end
    if (mode == 1) chk("latency", cyc - e.cyc, 2);
  endtask

  // mode 0: out_ready low, 1: high, 2: random
  task automatic cycle(input int mode);
    if (last_acc) bus.in_valid = 1'b0;
    last_acc = 1'b0;
    if (!bus.in_valid && stim.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.mcand = stim[0].a;
      bus.mplier = stim[0].b;
      bus.in_tag = stim[0].tag;
    end
    bus.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    #1;
    chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
    if (q.size() == 2) chk("full_ov", bus.out_valid, 1);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else compare(mode);
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_t e;
      e = stim.pop_front();
      e.cyc = cyc;
      q.push_back(e);
      last_acc = 1'b1;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int mode);
    int n;
    n = 0;
    while ((stim.size() > 0 || q.size() > 0 || bus.in_valid) && n < 4000) begin
      cycle(mode);
      n++;
    end
    if (n >= 4000) chk("run_timeout", 1, 0);
    if (last_acc) bus.in_valid = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic fill_two();
    int n;
    n = 0;
    add(16'h0003, 16'h0001);
    add(16'h1234, 16'h0005);
    while (q.size() < 2 && n < 20) begin
      cycle(0);
      n++;
    end
    if (last_acc) bus.in_valid = 1'b0;
    last_acc = 1'b0;
    chk("fill_two", q.size(), 2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.mcand = '0;
    bus.mplier = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_pp", observed(), '0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    stim.push_back(model(16'h0003, 16'h0005, 4'd1));
    add(16'hFFFF, 16'hFFFF);
    add(16'h7FFF, 16'h8000);
    add(16'h8000, 16'h0002);
    add(16'h8000, 16'h0001);
    add(16'h8000, 16'hAAAA);
    add(16'h0000, 16'h5555);
    run(1);

    for (int i = 0; i < 5; i++) add(16'($urandom), 16'($urandom));
    run(2);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if (i % 7 == 0) a = 16'h8000;
      if (i % 11 == 0) a = 16'h7FFF;
      add(a, 16'($urandom));
    end
    run(2);

    fill_two();
    flush = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.mcand = 16'h0042;
    bus.mplier = 16'h0001;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    q.delete();
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready_after", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("flush_no_output", bus.out_valid, 0);
    end

    fill_two();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_pp", observed(), '0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_tag", bus.out_tag, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("arst_no_output", bus.out_valid, 0);
    end
    @(negedge clk);

    add(16'h0003, 16'h0005);
    add(16'h8000, 16'h0002);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
